cache_line_reader: RTL and testbench

- Consumer side of the cache line storage block. Takes the stored line outputs (tag, 512-bit block, valid, dirty) and serves lookup requests: tag compare, hit flag and selected 32-bit word.
- On a miss against a valid, dirty line, streams the victim block to the memory side as 16 x 32-bit beats over a valid/ready handshake.
- Then pulses a dirty-clear strobe back to the line.

---
 rtl/cache_line_reader_if.sv | 53 +++++
 rtl/cache_line_reader.sv | 171 +++++++++++++++++
 tb/tb_cache_line_reader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_line_reader_if.sv
// rtl/cache_line_reader_if.sv - line, lookup, response and writeback signal bundle for cache_line_reader
//
// Purpose: groups the stored-line inputs, the lookup request/response and
// the writeback stream of cache_line_reader into one bundle.
// Modports:
//   slave  - used by cache_line_reader (consumes line + request, drives response/writeback)
//   master - used by the line storage / requester / memory side
// Signals:
//   line_tag/line_blk/line_v/line_d  stored line contents
//   req_valid/req_ready/req_tag/req_off  lookup request handshake
//   rsp_valid/rsp_hit/rsp_word  one-cycle lookup response
//   wb_valid/wb_ready/wb_data/wb_tag/wb_beat/wb_last  victim writeback beats
//   line_clr_d  dirty-clear strobe, busy  block not idle
interface cache_line_reader_if #(
    parameter int TAG_W  = 19,
    parameter int BLK_W  = 512,
    parameter int WORD_W = 32,
    parameter int OFF_W  = 4
) ();
    logic [TAG_W-1:0]  line_tag;
    logic [BLK_W-1:0]  line_blk;
    logic              line_v;
    logic              line_d;
    logic              req_valid;
    logic              req_ready;
    logic [TAG_W-1:0]  req_tag;
    logic [OFF_W-1:0]  req_off;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [WORD_W-1:0] rsp_word;
    logic              wb_valid;
    logic              wb_ready;
    logic [WORD_W-1:0] wb_data;
    logic [TAG_W-1:0]  wb_tag;
    logic [OFF_W-1:0]  wb_beat;
    logic              wb_last;
    logic              line_clr_d;
    logic              busy;

    modport slave (
        input  line_tag, line_blk, line_v, line_d,
        input  req_valid, req_tag, req_off, wb_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_word,
        output wb_valid, wb_data, wb_tag, wb_beat, wb_last, line_clr_d, busy
    );

    modport master (
        output line_tag, line_blk, line_v, line_d,
        output req_valid, req_tag, req_off, wb_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_word,
        input  wb_valid, wb_data, wb_tag, wb_beat, wb_last, line_clr_d, busy
    );
endinterface

// File: rtl/cache_line_reader.sv
// rtl/cache_line_reader.sv - cache line lookup with dirty-victim writeback
//
// Purpose: serves tag/offset lookups against a snapshot of the stored line,
// returns hit and selected word, and on a miss against a valid dirty line
// streams the victim block as BEATS words, then pulses line_clr_d.
// Ports:
//   clk    rising-edge clock
//   rst_b  asynchronous, active-high reset
//   bus    cache_line_reader_if.slave (line inputs, request, response, writeback)
module cache_line_reader #(
    parameter int TAG_W  = 19,
    parameter int BLK_W  = 512,
    parameter int WORD_W = 32,
    parameter int BEATS  = BLK_W / WORD_W,
    parameter int OFF_W  = $clog2(BEATS)
) (
    input logic                clk,
    input logic                rst_b,
    cache_line_reader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RESP,
        S_WB,
        S_WB_DONE
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_req_tag;
    logic [OFF_W-1:0]   r_req_off;
    logic [TAG_W-1:0]   r_snap_tag;
    logic [BLK_W-1:0]   r_snap_blk;
    logic               r_snap_v;
    logic               r_snap_d;
    logic               r_hit;
    logic [OFF_W-1:0]   r_cnt;

    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_rsp_hit;
    logic [WORD_W-1:0]  r_rsp_word;
    logic               r_wb_valid;
    logic [WORD_W-1:0]  r_wb_data;
    logic [TAG_W-1:0]   r_wb_tag;
    logic [OFF_W-1:0]   r_wb_beat;
    logic               r_wb_last;
    logic               r_line_clr_d;
    logic               r_busy;

    // Word view of the snapshot block; word 0 is the LSBs.
    logic [WORD_W-1:0]  w_words [BEATS];
    logic               w_hit;
    logic [OFF_W-1:0]   w_cnt_nxt;

    for (genvar g = 0; g < BEATS; g++) begin : g_words
        assign w_words[g] = r_snap_blk[g*WORD_W +: WORD_W];
    end

    assign w_hit     = r_snap_v && (r_snap_tag == r_req_tag);
    assign w_cnt_nxt = r_cnt + 1'b1;

    // Outputs are registered one state ahead so each lands in the cycle
    // its state is occupied.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state      <= S_IDLE;
            r_req_tag    <= '0;
            r_req_off    <= '0;
            r_snap_tag   <= '0;
            r_snap_blk   <= '0;
            r_snap_v     <= 1'b0;
            r_snap_d     <= 1'b0;
            r_hit        <= 1'b0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_word   <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_tag     <= '0;
            r_wb_beat    <= '0;
            r_wb_last    <= 1'b0;
            r_line_clr_d <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_req_tag   <= bus.req_tag;
                        r_req_off   <= bus.req_off;
                        r_snap_tag  <= bus.line_tag;
                        r_snap_blk  <= bus.line_blk;
                        r_snap_v    <= bus.line_v;
                        r_snap_d    <= bus.line_d;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_hit       <= w_hit;
                    r_rsp_valid <= 1'b1;
                    r_rsp_hit   <= w_hit;
                    r_rsp_word  <= w_hit ? w_words[r_req_off] : '0;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_hit   <= 1'b0;
                    r_rsp_word  <= '0;
                    if (!r_hit && r_snap_v && r_snap_d) begin
                        r_cnt      <= '0;
                        r_wb_valid <= 1'b1;
                        r_wb_data  <= w_words[0];
                        r_wb_tag   <= r_snap_tag;
                        r_wb_beat  <= '0;
                        r_wb_last  <= (OFF_W'(BEATS - 1) == '0);
                        r_state    <= S_WB;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_WB: begin
                    // Beat registers only move on a transfer, so they hold under backpressure.
                    if (bus.wb_ready) begin
                        if (r_cnt == OFF_W'(BEATS - 1)) begin
                            r_cnt        <= '0;
                            r_wb_valid   <= 1'b0;
                            r_wb_data    <= '0;
                            r_wb_tag     <= '0;
                            r_wb_beat    <= '0;
                            r_wb_last    <= 1'b0;
                            r_line_clr_d <= 1'b1;
                            r_state      <= S_WB_DONE;
                        end else begin
                            r_cnt     <= w_cnt_nxt;
                            r_wb_data <= w_words[w_cnt_nxt];
                            r_wb_beat <= w_cnt_nxt;
                            r_wb_last <= (w_cnt_nxt == OFF_W'(BEATS - 1));
                        end
                    end
                end
                S_WB_DONE: begin
                    r_line_clr_d <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_hit    = r_rsp_hit;
    assign bus.rsp_word   = r_rsp_word;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_data    = r_wb_data;
    assign bus.wb_tag     = r_wb_tag;
    assign bus.wb_beat    = r_wb_beat;
    assign bus.wb_last    = r_wb_last;
    assign bus.line_clr_d = r_line_clr_d;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_cache_line_reader.sv
// tb/tb_cache_line_reader.sv - self-checking bench for cache_line_reader
module tb_cache_line_reader;
    localparam int TAG_W = 19, BLK_W = 512, WORD_W = 32, BEATS = 16, OFF_W = 4;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    cache_line_reader_if #(.TAG_W(TAG_W), .BLK_W(BLK_W), .WORD_W(WORD_W), .OFF_W(OFF_W)) bus ();

    cache_line_reader #(.TAG_W(TAG_W), .BLK_W(BLK_W), .WORD_W(WORD_W), .BEATS(BEATS), .OFF_W(OFF_W)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Observations collected by run_req for one request.
    logic [31:0] q_data[$];
    int          q_idx[$];
    logic [18:0] q_tag[$];
    int          q_last[$];
    int          rsp_cyc[$];
    int          clr_cyc[$];
    logic [31:0] stall_data[$];
    logic        got_hit;
    logic [31:0] got_word;
    logic        ready_at_idle;
    int          first_wb, idle_cyc, viol;
    bit          timeout;
    logic        ab_valid, ab_busy, ab_clr;
    logic [3:0]  ab_beat;

    // Reference: word i of a block is bits [32i+31:32i].
    function automatic logic [31:0] word_of(input logic [511:0] blk, input int i);
        return 32'(blk >> (32 * i));
    endfunction

    // Number of differences between the recorded beats and a full victim burst of blk/tag.
    function automatic int wb_mismatch(input logic [511:0] blk, input logic [18:0] tag);
        int bad = 0;
        if (q_data.size() != BEATS) return 100;
        for (int i = 0; i < BEATS; i++) begin
            if (q_data[i] !== word_of(blk, i)) bad++;
            if (q_idx[i] != i) bad++;
            if (q_tag[i] !== tag) bad++;
        end
        return bad;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b = '0;
        for (int i = 0; i < BEATS; i++) b = b | (512'($urandom) << (32 * i));
        return b;
    endfunction

    // Issues one request from IDLE and records everything until busy drops.
    // Cycle 1 is the cycle after the accepting edge.
    task automatic run_req(input logic [18:0] rtag, input logic [3:0] roff,
                           input bit change_blk, input logic [511:0] alt_blk,
                           input int stall_beat, input int stall_len, input int abort_beat);
        logic        prev_pending;
        logic [31:0] prev_data;
        logic [3:0]  prev_beat;
        int          stall_left;
        q_data.delete(); q_idx.delete(); q_tag.delete(); q_last.delete();
        rsp_cyc.delete(); clr_cyc.delete(); stall_data.delete();
        got_hit = 1'b0; got_word = '0; ready_at_idle = 1'b0;
        first_wb = -1; idle_cyc = -1; viol = 0; timeout = 1'b0;
        ab_valid = 1'b1; ab_busy = 1'b1; ab_clr = 1'b1; ab_beat = 4'hF;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_tag = rtag; bus.req_off = roff; bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (change_blk) bus.line_blk = alt_blk;
        prev_pending = 1'b0; prev_data = '0; prev_beat = '0;
        stall_left = stall_len;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (bus.wb_valid && !bus.busy) viol++;
            if (prev_pending && !(bus.wb_valid && bus.wb_data === prev_data && bus.wb_beat === prev_beat)) viol++;
            if (bus.rsp_valid) begin
                rsp_cyc.push_back(cyc); got_hit = bus.rsp_hit; got_word = bus.rsp_word;
            end
            if (bus.line_clr_d) clr_cyc.push_back(cyc);
            if (bus.wb_valid && first_wb < 0) first_wb = cyc;
            if (abort_beat >= 0 && bus.wb_valid && int'(bus.wb_beat) == abort_beat) begin
                #1 rst_b = 1'b1;
                #1;
                ab_valid = bus.wb_valid; ab_busy = bus.busy; ab_beat = bus.wb_beat; ab_clr = bus.line_clr_d;
                @(posedge clk);
                #1 ab_clr = ab_clr | bus.line_clr_d;
                @(negedge clk);
                rst_b = 1'b0;
                return;
            end
            if (bus.wb_valid && int'(bus.wb_beat) == stall_beat && stall_left > 0) begin
                bus.wb_ready = 1'b0; stall_left--; stall_data.push_back(bus.wb_data);
            end else begin
                bus.wb_ready = 1'b1;
            end
            prev_pending = bus.wb_valid && !bus.wb_ready;
            prev_data = bus.wb_data; prev_beat = bus.wb_beat;
            if (bus.wb_valid && bus.wb_ready) begin
                q_data.push_back(bus.wb_data); q_idx.push_back(int'(bus.wb_beat)); q_tag.push_back(bus.wb_tag);
                if (bus.wb_last) q_last.push_back(int'(bus.wb_beat));
            end
            if (!bus.busy) begin
                idle_cyc = cyc; ready_at_idle = bus.req_ready;
                return;
            end
        end
        timeout = 1'b1;
    endtask

    task automatic test_reset();
        logic [31+32+19+4+6-1:0] outs;
        rst_b = 1'b1;
        #2;
        outs = {bus.rsp_valid, bus.rsp_hit, bus.rsp_word, bus.wb_valid, bus.wb_data,
                bus.wb_tag, bus.wb_beat, bus.wb_last, bus.line_clr_d, bus.busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected ready=1 busy=0", bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_hit();
        logic [511:0] blk = rand_blk();
        blk[5*32 +: 32] = 32'hDEADBEEF;
        bus.line_v = 1'b1; bus.line_d = 1'b0; bus.line_tag = 19'h12345; bus.line_blk = blk;
        run_req(19'h12345, 4'd5, 1'b0, '0, -1, 0, -1);
        checks++;
        if (rsp_cyc.size() != 1 || rsp_cyc[0] != 2) begin
            errors++; $display("FAIL hit_rsp_timing: got %0d pulses first at %0d expected 1 at 2", rsp_cyc.size(), rsp_cyc.size() ? rsp_cyc[0] : -1);
        end
        checks++;
        if (got_hit !== 1'b1 || got_word !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hit_rsp: got hit=%b word=%h expected hit=1 word=deadbeef", got_hit, got_word);
        end
        checks++;
        if (first_wb != -1 || idle_cyc != 3 || ready_at_idle !== 1'b1 || timeout) begin
            errors++; $display("FAIL hit_no_wb: got wb_at=%0d idle_at=%0d ready=%b timeout=%0d expected -1 3 1 0", first_wb, idle_cyc, ready_at_idle, timeout);
        end
    endtask

    task automatic test_clean_miss();
        bus.line_v = 1'b1; bus.line_d = 1'b0; bus.line_tag = 19'h12345; bus.line_blk = rand_blk();
        run_req(19'h00001, 4'd3, 1'b0, '0, -1, 0, -1);
        checks++;
        if (rsp_cyc.size() != 1 || rsp_cyc[0] != 2 || got_hit !== 1'b0 || got_word !== '0) begin
            errors++; $display("FAIL clean_miss_rsp: got pulses=%0d hit=%b word=%h expected 1 0 0", rsp_cyc.size(), got_hit, got_word);
        end
        checks++;
        if (first_wb != -1 || clr_cyc.size() != 0 || idle_cyc != 3) begin
            errors++; $display("FAIL clean_miss_no_wb: got wb_at=%0d clr=%0d idle_at=%0d expected -1 0 3", first_wb, clr_cyc.size(), idle_cyc);
        end
    endtask

    task automatic test_dirty_miss();
        logic [511:0] blk = '0;
        int m;
        for (int i = 0; i < BEATS; i++) blk = blk | (512'(32'h100 + i) << (32 * i));
        bus.line_v = 1'b1; bus.line_d = 1'b1; bus.line_tag = 19'h7ABCD; bus.line_blk = blk;
        run_req(19'h00002, 4'd0, 1'b0, '0, -1, 0, -1);
        m = wb_mismatch(blk, 19'h7ABCD);
        checks++;
        if (m != 0) begin errors++; $display("FAIL dirty_wb_seq: got %0d beats %0d mismatches expected 16 beats 0 mismatches", q_data.size(), m); end
        checks++;
        if (first_wb != 3 || got_hit !== 1'b0) begin errors++; $display("FAIL dirty_wb_start: got first=%0d hit=%b expected 3 0", first_wb, got_hit); end
        checks++;
        if (q_last.size() != 1 || q_last[0] != 15) begin errors++; $display("FAIL dirty_wb_last: got %0d marks expected one on beat 15", q_last.size()); end
        checks++;
        if (clr_cyc.size() != 1 || clr_cyc[0] != 19 || idle_cyc != 20 || viol != 0) begin
            errors++; $display("FAIL dirty_wb_done: got clr=%0d at %0d idle=%0d viol=%0d expected 1 at 19 idle 20 viol 0",
                               clr_cyc.size(), clr_cyc.size() ? clr_cyc[0] : -1, idle_cyc, viol);
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] blk = '0;
        int m, bad_stall;
        for (int i = 0; i < BEATS; i++) blk = blk | (512'(32'h100 + i) << (32 * i));
        bus.line_v = 1'b1; bus.line_d = 1'b1; bus.line_tag = 19'h7ABCD; bus.line_blk = blk;
        run_req(19'h00002, 4'd1, 1'b1, {512{1'b1}}, 7, 3, -1);
        bad_stall = (stall_data.size() == 3) ? 0 : 1;
        foreach (stall_data[i]) if (stall_data[i] !== 32'h107) bad_stall++;
        checks++;
        if (bad_stall != 0 || viol != 0) begin errors++; $display("FAIL bp_hold: got stalls=%0d bad=%0d viol=%0d expected 3 0 0", stall_data.size(), bad_stall, viol); end
        m = wb_mismatch(blk, 19'h7ABCD);
        checks++;
        if (m != 0) begin errors++; $display("FAIL bp_wb_seq: got %0d beats %0d mismatches expected 16 beats 0 mismatches", q_data.size(), m); end
        checks++;
        if (clr_cyc.size() != 1 || clr_cyc[0] != 22 || idle_cyc != 23) begin
            errors++; $display("FAIL bp_done: got clr=%0d idle=%0d expected clr at 22 idle 23", clr_cyc.size() ? clr_cyc[0] : -1, idle_cyc);
        end
    endtask

    task automatic test_reset_mid_wb();
        logic [511:0] blk = rand_blk();
        int m;
        bus.line_v = 1'b1; bus.line_d = 1'b1; bus.line_tag = 19'h0BEEF; bus.line_blk = blk;
        run_req(19'h00003, 4'd0, 1'b0, '0, -1, 0, 4);
        checks++;
        if (ab_valid !== 1'b0 || ab_busy !== 1'b0 || ab_beat !== 4'd0) begin
            errors++; $display("FAIL abort_async: got valid=%b busy=%b beat=%0d expected 0 0 0", ab_valid, ab_busy, ab_beat);
        end
        checks++;
        if (ab_clr !== 1'b0 || clr_cyc.size() != 0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL abort_no_clr: got clr=%b clr_pulses=%0d ready=%b expected 0 0 1", ab_clr, clr_cyc.size(), bus.req_ready);
        end
        run_req(19'h00004, 4'd0, 1'b0, '0, -1, 0, -1);
        m = wb_mismatch(blk, 19'h0BEEF);
        checks++;
        if (m != 0 || clr_cyc.size() != 1) begin errors++; $display("FAIL abort_restart: got %0d mismatches %0d clr expected 0 1", m, clr_cyc.size()); end
    endtask

    task automatic test_invalid_dirty();
        logic [511:0] blk2 = rand_blk();
        logic [3:0]   off = 4'($urandom_range(0, 15));
        int           r_cycles[$];
        logic         hits[$];
        logic [31:0]  words[$];
        logic         rdy[8];
        bit           any_wb = 1'b0;
        bus.line_v = 1'b0; bus.line_d = 1'b1; bus.line_tag = 19'h2AAAA; bus.line_blk = rand_blk();
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_tag = 19'h2AAAA; bus.req_off = off; bus.wb_ready = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            rdy[cyc] = bus.req_ready;
            if (bus.rsp_valid) begin r_cycles.push_back(cyc); hits.push_back(bus.rsp_hit); words.push_back(bus.rsp_word); end
            if (bus.wb_valid) any_wb = 1'b1;
            if (cyc == 1) begin bus.line_v = 1'b1; bus.line_blk = blk2; end
            if (cyc == 4) bus.req_valid = 1'b0;
        end
        checks++;
        if (r_cycles.size() != 2 || r_cycles[0] != 2 || r_cycles[1] != 5) begin
            errors++; $display("FAIL hold_accept: got %0d responses first at %0d expected at 2 and 5", r_cycles.size(), r_cycles.size() ? r_cycles[0] : -1);
        end else begin
            checks++;
            if (hits[0] !== 1'b0 || words[0] !== '0 || hits[1] !== 1'b1 || words[1] !== word_of(blk2, int'(off))) begin
                errors++; $display("FAIL invalid_dirty_rsp: got hit0=%b hit1=%b word1=%h expected 0 1 %h", hits[0], hits[1], words[1], word_of(blk2, int'(off)));
            end
        end
        checks++;
        if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0 || rdy[3] !== 1'b1 || rdy[4] !== 1'b0 || any_wb) begin
            errors++; $display("FAIL invalid_dirty_ready: got %b%b%b%b wb=%0d expected 0010 wb=0", rdy[1], rdy[2], rdy[3], rdy[4], any_wb);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [511:0] blk = rand_blk();
            logic [18:0]  ltag = 19'($urandom);
            logic [18:0]  rtag = $urandom_range(0, 1) ? ltag : 19'($urandom);
            logic [3:0]   off = 4'($urandom_range(0, 15));
            logic         v = 1'($urandom_range(0, 1));
            logic         d = 1'($urandom_range(0, 1));
            int           sb = $urandom_range(0, 15);
            int           sl = $urandom_range(0, 2);
            logic         e_hit = v && (ltag == rtag);
            logic [31:0]  e_word = e_hit ? word_of(blk, int'(off)) : 32'h0;
            bit           e_wb = !e_hit && v && d;
            bus.line_v = v; bus.line_d = d; bus.line_tag = ltag; bus.line_blk = blk;
            run_req(rtag, off, 1'b1, rand_blk(), sb, sl, -1);
            checks++;
            if (rsp_cyc.size() != 1 || got_hit !== e_hit || got_word !== e_word) begin
                errors++; $display("FAIL rand_rsp[%0d]: got pulses=%0d hit=%b word=%h expected 1 %b %h", n, rsp_cyc.size(), got_hit, got_word, e_hit, e_word);
            end
            checks++;
            if (e_wb) begin
                if (wb_mismatch(blk, ltag) != 0 || clr_cyc.size() != 1 || idle_cyc != 20 + sl || viol != 0) begin
                    errors++; $display("FAIL rand_wb[%0d]: got beats=%0d clr=%0d idle=%0d viol=%0d expected 16 1 %0d 0", n, q_data.size(), clr_cyc.size(), idle_cyc, 20 + sl, viol);
                end
            end else begin
                if (q_data.size() != 0 || clr_cyc.size() != 0 || idle_cyc != 3) begin
                    errors++; $display("FAIL rand_nowb[%0d]: got beats=%0d clr=%0d idle=%0d expected 0 0 3", n, q_data.size(), clr_cyc.size(), idle_cyc);
                end
            end
        end
    endtask

    initial begin
        bus.line_tag = '0; bus.line_blk = '0; bus.line_v = 1'b0; bus.line_d = 1'b0;
        bus.req_valid = 1'b0; bus.req_tag = '0; bus.req_off = '0; bus.wb_ready = 1'b1;
        test_reset();
        test_hit();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_reset_mid_wb();
        test_invalid_dirty();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
